// File: rtl/writeback_queue_pkg.sv
// Shared load encodings and the queue entry layout for the writeback path.
// Field widths are sized for the widest supported configuration; the queue narrows them on use.
package riscv;

  localparam int ENTRY_DATA_W = 64;
  localparam int ENTRY_RD_W   = 8;
  localparam int ENTRY_OFF_W  = 3;

  typedef enum logic [2:0] {
    MEM_LB  = 3'b000,
    MEM_LH  = 3'b001,
    MEM_LW  = 3'b010,
    MEM_LD  = 3'b011,
    MEM_LBU = 3'b100,
    MEM_LHU = 3'b101,
    MEM_LWU = 3'b110
  } memory_op_e;

  typedef struct packed {
    logic [ENTRY_RD_W-1:0]   rd;
    logic                    wen;
    logic                    is_load;
    logic [2:0]              f3;
    logic [ENTRY_OFF_W-1:0]  byte_off;
    logic [ENTRY_DATA_W-1:0] data;
    logic                    ready;
  } entry_t;

endpackage

// File: rtl/writeback_queue_if.sv
// Memory-stage, load-response and register-file signals of the writeback queue.
interface writeback_queue_if #(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int REG_W = 5
);
    localparam int OFF_W = $clog2(XLEN / 8);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic             in_valid;
    logic             in_ready;
    logic             in_is_load;
    logic [2:0]       in_f3;
    logic [OFF_W-1:0] in_byte_off;
    logic [REG_W-1:0] in_rd;
    logic             in_wen;
    logic [XLEN-1:0]  in_data;
    logic             rsp_valid;
    logic [XLEN-1:0]  rsp_data;
    logic             wb_retire;
    logic             wb_valid;
    logic [REG_W-1:0] wb_rd;
    logic [XLEN-1:0]  wb_data;
    logic [CNT_W-1:0] pending_loads;
    logic             err_rsp;

    modport master (
        output in_valid, in_is_load, in_f3, in_byte_off, in_rd, in_wen, in_data,
        output rsp_valid, rsp_data,
        input  in_ready, wb_retire, wb_valid, wb_rd, wb_data, pending_loads, err_rsp
    );

    modport slave (
        input  in_valid, in_is_load, in_f3, in_byte_off, in_rd, in_wen, in_data,
        input  rsp_valid, rsp_data,
        output in_ready, wb_retire, wb_valid, wb_rd, wb_data, pending_loads, err_rsp
    );
endinterface

// File: rtl/writeback_queue_load_align.sv
// Combinational load data alignment: shift the raw word down to the addressed byte,
// then sign- or zero-extend according to the load funct3.
module load_align
    import riscv::*;
#(
    parameter  int XLEN  = 32,
    localparam int OFF_W = $clog2(XLEN / 8)
) (
    input  logic [XLEN-1:0]  raw,
    input  logic [2:0]       f3,
    input  logic [OFF_W-1:0] byte_off,
    output logic [XLEN-1:0]  result
);
    function automatic logic [XLEN-1:0] sext8(input logic signed [7:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] sext16(input logic signed [15:0] v);
        return XLEN'(v);
    endfunction

    function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
        return XLEN'(v);
    endfunction

    logic [XLEN-1:0] shifted;

    always_comb begin
        shifted = raw >> {byte_off, 3'b000};
        result  = shifted;
        case (f3)
            MEM_LB:  result = sext8(shifted[7:0]);
            MEM_LH:  result = sext16(shifted[15:0]);
            MEM_LW:  result = sext32(shifted[31:0]);
            MEM_LBU: result = XLEN'(shifted[7:0]);
            MEM_LHU: result = XLEN'(shifted[15:0]);
            MEM_LWU: result = XLEN'(shifted[31:0]);
            default: result = shifted;
        endcase
    end
endmodule

// File: rtl/writeback_queue.sv
// In-order writeback queue: ALU results and outstanding loads retire to the register file
// in program order; load data is filled from in-order memory responses.
module writeback_queue
    import riscv::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 4,
    parameter int REG_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    writeback_queue_if.slave bus
);
    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int OFF_W = $clog2(XLEN / 8);

    typedef logic [PTR_W-1:0] ptr_t;

    function automatic ptr_t next_ptr(input ptr_t p);
        return (p == ptr_t'(DEPTH - 1)) ? '0 : p + ptr_t'(1);
    endfunction

    entry_t           entries_q [DEPTH];
    entry_t           entries_d [DEPTH];
    ptr_t             head_q, head_d, tail_q, tail_d, fill_ptr;
    logic [CNT_W-1:0] count_q, count_d, pending_q, pending_d;
    logic             err_q, err_d;
    logic             enq, deq, rsp_fill, fill_found;
    logic [XLEN-1:0]  load_val;
    entry_t           head_e, fill_e;
    logic             unused_entry_bits;

    assign head_e            = entries_q[head_q];
    assign fill_e            = entries_q[fill_ptr];
    assign unused_entry_bits = ^{head_e, fill_e};

    load_align #(.XLEN(XLEN)) u_load_align (
        .raw      (bus.rsp_data),
        .f3       (fill_e.f3),
        .byte_off (fill_e.byte_off[OFF_W-1:0]),
        .result   (load_val)
    );

    // Load-fill pointer: oldest occupied load still waiting for data, searched from the head.
    always_comb begin
        fill_ptr   = head_q;
        fill_found = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (!fill_found && (i < int'(count_q)) &&
                entries_q[ptr_t'(head_q + ptr_t'(i))].is_load &&
                !entries_q[ptr_t'(head_q + ptr_t'(i))].ready) begin
                fill_ptr   = ptr_t'(head_q + ptr_t'(i));
                fill_found = 1'b1;
            end
        end
    end

    always_comb begin
        bus.in_ready = (count_q < CNT_W'(DEPTH));
        enq          = bus.in_valid && bus.in_ready;
        deq          = (count_q != '0) && head_e.ready;
        rsp_fill     = bus.rsp_valid && (pending_q != '0) && fill_found;

        entries_d = entries_q;
        head_d    = head_q;
        tail_d    = tail_q;
        count_d   = count_q;
        pending_d = pending_q;
        err_d     = err_q || (bus.rsp_valid && (pending_q == '0));

        if (deq) begin
            entries_d[head_q].ready = 1'b0;
            head_d                  = next_ptr(head_q);
        end
        if (enq) begin
            entries_d[tail_q] = '{
                rd:       ENTRY_RD_W'(bus.in_rd),
                wen:      bus.in_wen,
                is_load:  bus.in_is_load,
                f3:       bus.in_f3,
                byte_off: ENTRY_OFF_W'(bus.in_byte_off),
                data:     ENTRY_DATA_W'(bus.in_data),
                ready:    !bus.in_is_load
            };
            tail_d = next_ptr(tail_q);
        end
        if (rsp_fill) begin
            entries_d[fill_ptr].data  = ENTRY_DATA_W'(load_val);
            entries_d[fill_ptr].ready = 1'b1;
        end

        if (enq && !deq) count_d = count_q + CNT_W'(1);
        if (deq && !enq) count_d = count_q - CNT_W'(1);
        if (enq && bus.in_is_load) pending_d = pending_d + CNT_W'(1);
        if (rsp_fill)              pending_d = pending_d - CNT_W'(1);

        bus.wb_retire     = deq;
        bus.wb_valid      = deq && head_e.wen && (head_e.rd[REG_W-1:0] != '0);
        bus.wb_rd         = bus.wb_valid ? head_e.rd[REG_W-1:0] : '0;
        bus.wb_data       = bus.wb_valid ? head_e.data[XLEN-1:0] : '0;
        bus.pending_loads = pending_q;
        bus.err_rsp       = err_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            pending_q <= '0;
            err_q     <= 1'b0;
            for (int i = 0; i < DEPTH; i++) entries_q[i].ready <= 1'b0;
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            pending_q <= pending_d;
            err_q     <= err_d;
            entries_q <= entries_d;
        end
    end
endmodule
